// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_loader
// Purpose  : Serialises host bitstream words MSB-first onto a configuration
//            scan chain and reports completion after CHAIN_LENGTH shifts.
// Option   : CONFIG_VERIFY_EN adds a recirculating CRC-16-CCITT readback check.
// Revision : 1.0
// ============================================================================
module config_loader #(
  parameter int CHAIN_LENGTH = 24,
  parameter int WORD_WIDTH   = 8,
  parameter int CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  config_clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_out,
  output logic                  chain_en,
  input  logic                  chain_in
);

  localparam int c_WORDS  = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int c_WCNT_W = $clog2(c_WORDS + 1);
  localparam int c_WB_W   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [CNT_W-1:0]    c_LAST_BIT = CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [c_WB_W-1:0]   c_LAST_WB  = c_WB_W'(WORD_WIDTH - 1);
  localparam logic [c_WCNT_W-1:0] c_WORDS_W  = c_WCNT_W'(c_WORDS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_buf;
  logic                  r_full;
  logic [c_WB_W-1:0]     r_wbit;
  logic [c_WCNT_W-1:0]   r_words;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_done;

  logic w_last_wbit;
  logic w_accept;
  logic w_last_shift;

  // A new word may land on the same edge the current one shifts its last bit,
  // which keeps the chain streaming without bubbles.
  assign w_last_wbit  = (r_wbit == c_LAST_WB);
  assign word_ready   = (r_state == S_LOAD) && (!r_full || w_last_wbit) && (r_words != c_WORDS_W);
  assign w_accept     = word_valid && word_ready;
  assign w_last_shift = r_full && (r_bit_cnt == c_LAST_BIT);

  assign busy = (r_state == S_LOAD) || (r_state == S_VERIFY);
  assign done = r_done;

`ifdef CONFIG_VERIFY_EN
  // Recirculation must be combinational so the bit leaving the tail re-enters
  // the head on the same edge, leaving the chain contents intact.
  assign chain_en  = r_full || (r_state == S_VERIFY);
  assign chain_out = (r_state == S_VERIFY) ? chain_in : r_buf[WORD_WIDTH-1];
`else
  logic w_unused_chain_in;
  assign w_unused_chain_in = chain_in;
  assign chain_en  = r_full;
  assign chain_out = r_buf[WORD_WIDTH-1];
  assign error     = 1'b0;
`endif

  always_ff @(posedge config_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_full    <= 1'b0;
      r_wbit    <= '0;
      r_words   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_LOAD;
            r_buf     <= '0;
            r_full    <= 1'b0;
            r_wbit    <= '0;
            r_words   <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (r_full) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last_shift) begin
              // Any unshifted low-order bits of the final word are dropped here.
              r_full    <= 1'b0;
              r_buf     <= '0;
              r_bit_cnt <= '0;
`ifdef CONFIG_VERIFY_EN
              r_state   <= S_VERIFY;
`else
              r_state   <= S_DONE;
              r_done    <= 1'b1;
`endif
            end else if (w_accept) begin
              r_buf   <= word_data;
              r_wbit  <= '0;
              r_words <= r_words + 1'b1;
            end else if (w_last_wbit) begin
              r_full <= 1'b0;
            end else begin
              r_buf  <= r_buf << 1;
              r_wbit <= r_wbit + 1'b1;
            end
          end else if (w_accept) begin
            r_buf   <= word_data;
            r_full  <= 1'b1;
            r_wbit  <= '0;
            r_words <= r_words + 1'b1;
          end
        end
`ifdef CONFIG_VERIFY_EN
        S_VERIFY: begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == c_LAST_BIT) begin
            r_bit_cnt <= '0;
            r_state   <= S_DONE;
            r_done    <= 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CONFIG_VERIFY_EN
  localparam logic [15:0] c_CRC_INIT = 16'hFFFF;
  localparam logic [15:0] c_CRC_POLY = 16'h1021;

  logic [15:0] r_crc_load;
  logic [15:0] r_crc_chk;
  logic        r_error;
  logic [15:0] w_crc_chk_next;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? c_CRC_POLY : 16'h0000);
  endfunction

  assign w_crc_chk_next = crc_step(r_crc_chk, chain_in);
  assign error          = r_error;

  always_ff @(posedge config_clk) begin
    if (reset) begin
      r_crc_load <= c_CRC_INIT;
      r_crc_chk  <= c_CRC_INIT;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_crc_load <= c_CRC_INIT;
            r_crc_chk  <= c_CRC_INIT;
            r_error    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (r_full) r_crc_load <= crc_step(r_crc_load, r_buf[WORD_WIDTH-1]);
        end
        S_VERIFY: begin
          r_crc_chk <= w_crc_chk_next;
          if (r_bit_cnt == c_LAST_BIT) r_error <= (w_crc_chk_next != r_crc_load);
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_loader
// Purpose  : Randomised self-checking bench for config_loader (24- and 20-bit
//            chains) against a bit-stream reference model and chain model.
// Revision : 1.0
// ============================================================================
module tb_config_loader;

  localparam int S_IDLE = 0, S_LOAD = 1, S_VERIFY = 2, S_DONE = 3;

  logic       clk;
  logic [1:0] rst_a, start_a, valid_a;
  logic [7:0] data_a [2];
  wire        busy0, busy1, done0, done1, err0, err1, rdy0, rdy1;
  wire        cout0, cout1, cen0, cen1;
  wire  [1:0] busy_a = {busy1, busy0};
  wire  [1:0] done_a = {done1, done0};
  wire  [1:0] err_a  = {err1, err0};
  wire  [1:0] rdy_a  = {rdy1, rdy0};
  wire  [1:0] cout_a = {cout1, cout0};
  wire  [1:0] cen_a  = {cen1, cen0};
  logic [23:0] chain [2];
  wire  [1:0] cin_a = {chain[1][19], chain[0][23]};

  // reference model state: accepted bits form one MSB-first stream per DUT
  int          m_state [2], m_shifted [2], m_words [2], m_vcnt [2];
  logic        m_done [2], m_err [2], m_vmis [2], flip_req [2];
  logic [31:0] stream [2];
  int          st_en [2], st_stall [2];
  logic [31:0] st_bits [2];
  int          n_cmp, n_bad;
  bit          chk_on;

  config_loader #(.CHAIN_LENGTH(24), .WORD_WIDTH(8)) dut0 (
    .config_clk(clk), .reset(rst_a[0]), .start(start_a[0]), .busy(busy0), .done(done0),
    .error(err0), .word_data(data_a[0]), .word_valid(valid_a[0]), .word_ready(rdy0),
    .chain_out(cout0), .chain_en(cen0), .chain_in(cin_a[0]));

  config_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(8)) dut1 (
    .config_clk(clk), .reset(rst_a[1]), .start(start_a[1]), .busy(busy1), .done(done1),
    .error(err1), .word_data(data_a[1]), .word_valid(valid_a[1]), .word_ready(rdy1),
    .chain_out(cout1), .chain_en(cen1), .chain_in(cin_a[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cl_of(input int i);
    return (i == 0) ? 24 : 20;
  endfunction

  function automatic logic m_ready(input int i);
    return (m_state[i] == S_LOAD) && (m_words[i] * 8 - m_shifted[i] <= 1) &&
           (m_words[i] < (cl_of(i) + 7) / 8);
  endfunction

  function automatic logic m_en(input int i);
    return ((m_state[i] == S_LOAD) && (m_words[i] * 8 > m_shifted[i])) || (m_state[i] == S_VERIFY);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 'h%0h expected 'h%0h (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  // model + physical chain update
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin : g_model
      logic acc, en;
      int   cl;
      cl  = cl_of(i);
      acc = valid_a[i] && m_ready(i);
      en  = m_en(i);
      if (cen_a[i])
        chain[i] <= {chain[i][22:0], cout_a[i]} ^
                    ((flip_req[i] && m_state[i] == S_LOAD && m_shifted[i] == cl - 1) ? 24'h000020 : 24'h0);
      if (rst_a[i]) begin
        m_state[i] = S_IDLE; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end else begin
        case (m_state[i])
          S_IDLE, S_DONE: if (start_a[i]) begin
            m_state[i] = S_LOAD; m_shifted[i] = 0; m_words[i] = 0; m_vcnt[i] = 0;
            m_done[i] = 1'b0; m_err[i] = 1'b0; m_vmis[i] = 1'b0;
            st_en[i] = 0; st_stall[i] = 0; st_bits[i] = '0;
          end
          S_LOAD: begin
            if (en) begin
              st_en[i]++;
              st_bits[i] = {st_bits[i][30:0], cout_a[i]};
              m_shifted[i]++;
              if (m_shifted[i] == cl) begin
`ifdef CONFIG_VERIFY_EN
                m_state[i] = S_VERIFY;
`else
                m_state[i] = S_DONE; m_done[i] = 1'b1;
`endif
              end
            end else if (m_shifted[i] > 0) st_stall[i]++;
            if (acc) begin
              stream[i][31 - 8 * m_words[i] -: 8] = data_a[i];
              m_words[i]++;
            end
          end
          S_VERIFY: begin
            if (cin_a[i] !== stream[i][31 - m_vcnt[i]]) m_vmis[i] = 1'b1;
            m_vcnt[i]++;
            if (m_vcnt[i] == cl) begin
              m_state[i] = S_DONE; m_done[i] = 1'b1; m_err[i] = m_vmis[i];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, busy_a[i], (m_state[i] == S_LOAD) || (m_state[i] == S_VERIFY));
        chk("done", i, done_a[i], m_done[i]);
        chk("error", i, err_a[i], m_err[i]);
        chk("word_ready", i, rdy_a[i], m_ready(i));
        chk("chain_en", i, cen_a[i], m_en(i));
        if (m_en(i))
          chk("chain_out", i, cout_a[i],
              (m_state[i] == S_VERIFY) ? cin_a[i] : stream[i][31 - m_shifted[i]]);
      end
    end
  end

  task automatic do_load(input int i, input logic [31:0] ws, input int n, input int stall,
                         input bit rnd, input int abort_at, input bit extra);
    int k, guard, extra_acc;
    bit acc;
    k = 0; guard = 0; extra_acc = 0;
    @(posedge clk); #1 start_a[i] = 1'b1;
    @(posedge clk); #1 start_a[i] = 1'b0;
    while (k < n && guard < 400) begin
      data_a[i]  = ws[31 - 8 * k -: 8];
      valid_a[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      start_a[i] = rnd && ($urandom_range(0, 5) == 0);
      @(negedge clk); acc = valid_a[i] && rdy_a[i];
      @(posedge clk); #1;
      start_a[i] = 1'b0;
      guard++;
      if (acc) begin
        k++;
        if (k == 1 && stall > 0) begin
          valid_a[i] = 1'b0;
          repeat (stall) @(posedge clk);
          #1;
        end
      end
      if (abort_at > 0 && st_en[i] >= abort_at) begin
        valid_a[i] = 1'b0;
        rst_a[i] = 1'b1;
        @(posedge clk); #1 rst_a[i] = 1'b0;
        chk("rst_busy", i, busy_a[i], 0);
        chk("rst_chain_en", i, cen_a[i], 0);
        chk("rst_word_ready", i, rdy_a[i], 0);
        return;
      end
    end
    valid_a[i] = 1'b0;
    chk("words_accepted", i, k, n);
    guard = 0;
    data_a[i]  = 8'hAA;
    valid_a[i] = extra;
    while (done_a[i] !== 1'b1 && guard < 200) begin
      start_a[i] = rnd && (m_state[i] == S_VERIFY) && (m_vcnt[i] < cl_of(i) - 2) &&
                   ($urandom_range(0, 3) == 0);
      @(negedge clk); if (valid_a[i] && rdy_a[i]) extra_acc++;
      @(posedge clk); #1;
      start_a[i] = 1'b0;
      guard++;
    end
    valid_a[i] = 1'b0;
    chk("done_reached", i, done_a[i], 1);
    if (extra) chk("extra_word_taken", i, extra_acc, 0);
  endtask

  initial begin
    logic [31:0] w;
    n_cmp = 0; n_bad = 0; chk_on = 1'b0;
    rst_a = 2'b11; start_a = '0; valid_a = '0;
    for (int i = 0; i < 2; i++) begin
      data_a[i] = '0; chain[i] = '0; stream[i] = '0; flip_req[i] = 1'b0;
      m_state[i] = S_IDLE; m_shifted[i] = 0; m_words[i] = 0; m_vcnt[i] = 0;
      m_done[i] = 1'b0; m_err[i] = 1'b0; m_vmis[i] = 1'b0;
      st_en[i] = 0; st_stall[i] = 0; st_bits[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 chk_on = 1'b1;
    chk("reset_busy", 0, busy_a[0], 0);
    chk("reset_done", 0, done_a[0], 0);
    chk("reset_error", 0, err_a[0], 0);
    chk("reset_ready", 0, rdy_a[0], 0);
    chk("reset_chain_en", 0, cen_a[0], 0);
    chk("reset_chain_out", 0, cout_a[0], 0);
    rst_a = 2'b00;

    // streaming load, no gaps
    do_load(0, 32'hA53CF000, 3, 0, 0, 0, 0);
    chk("stream_first8", 0, st_bits[0][23:16], 8'hA5);
    chk("stream_bits", 0, st_bits[0][23:0], 24'hA53CF0);
    chk("stream_chain", 0, chain[0], 24'hA53CF0);
    chk("stream_en_cycles", 0, st_en[0], 24);
    chk("stream_stalls", 0, st_stall[0], 0);
    chk("stream_error", 0, err_a[0], 0);

    // five-cycle stall after the first word
    do_load(0, 32'hA53CF000, 3, 12, 0, 0, 0);
    chk("stall_cycles", 0, st_stall[0], 5);
    chk("stall_en_cycles", 0, st_en[0], 24);
    chk("stall_chain", 0, chain[0], 24'hA53CF0);

    // partial final word on the 20-bit chain, 4th word offered
    do_load(1, 32'h12345F00, 3, 0, 0, 0, 1);
    chk("partial_en_cycles", 1, st_en[1], 20);
    chk("partial_chain", 1, chain[1][19:0], 20'h12345);

    // reset after 10 shifts, then a clean reload
    do_load(0, 32'h5A5A5A00, 3, 0, 0, 10, 0);
    do_load(0, 32'hA53CF000, 3, 0, 0, 0, 0);
    chk("reload_chain", 0, chain[0], 24'hA53CF0);

    // random words, random valid gaps, spurious start pulses
    repeat (6) begin
      w = $urandom;
      do_load(0, w, 3, 0, 1, 0, 0);
      chk("random_chain", 0, chain[0], w[31:8]);
    end

`ifdef CONFIG_VERIFY_EN
    // one chain bit corrupted between load and verify
    flip_req[0] = 1'b1;
    do_load(0, 32'hA53CF000, 3, 0, 0, 0, 0);
    flip_req[0] = 1'b0;
    chk("verify_fail_error", 0, err_a[0], 1);
    chk("verify_fail_chain", 0, chain[0], 24'hA53CD0);
    do_load(0, 32'hA53CF000, 3, 0, 1, 0, 0);
    chk("verify_pass_error", 0, err_a[0], 0);
    chk("verify_pass_chain", 0, chain[0], 24'hA53CF0);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
